pipe_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage core (F, D, E, M, W).
- Combines the hazard unit's load-use stall, the resolved branch/JALR redirect from E, JAL redirect from D, memory wait states and halt requests.
- Produces per-stage register enables, bubble clears, PC control and per-stage valid bits.
- Keeps stall and flush event counters for performance debug.

---
 rtl/pipe_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencer for the F/D/E/M/W pipeline. Merges load-use stalls,
// E/D redirects, memory wait states and halt/resume into per-stage enables,
// bubble clears and PC control, tracks per-stage valid bits and keeps
// stall/flush event counters for performance debug.
//
// Handshake note: IMEM_RDY and DMEM_RDY are single-cycle completion strobes
// sampled on the rising edge; there is no ready back-pressure towards the
// memories, the only response to a missing strobe is to hold or bubble stages.
`timescale 1ns/1ps

module pipe_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD_USE,
    input  logic             BR_TAKEN,
    input  logic             JAL_D,
    input  logic             IMEM_RDY,
    input  logic             DMEM_REQ,
    input  logic             DMEM_RDY,
    input  logic             HALT_REQ,
    input  logic             RESUME,
    output logic             PC_EN,
    output logic [1:0]       PC_SEL,
    output logic             F_EN,
    output logic             D_EN,
    output logic             E_EN,
    output logic             M_EN,
    output logic             W_EN,
    output logic             D_CLR,
    output logic             E_CLR,
    output logic [3:0]       STAGE_VALID,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [1:0] S_BOOT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_MWAIT = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    localparam int             BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0]  BOOT_LAST = BW'(BOOT_CYCLES - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [BW-1:0] boot_cnt;
    logic          active;     // RUN or MWAIT: the states that fetch and count
    logic          mem_wait;   // data access outstanding, whole pipe frozen
    logic          front_en;   // F->D and D->E registers
    logic          back_en;    // E->M, M->W and W registers
    logic          redirect;   // a branch/JALR or JAL redirect is accepted
    logic          d_src;      // valid of the instruction arriving into D

    assign active   = (state == S_RUN) || (state == S_MWAIT);
    assign mem_wait = ((state == S_RUN) && DMEM_REQ && !DMEM_RDY) ||
                      ((state == S_MWAIT) && !DMEM_RDY);
    assign d_src    = active && IMEM_RDY;

    assign F_EN  = front_en;
    assign D_EN  = front_en;
    assign E_EN  = back_en;
    assign M_EN  = back_en;
    assign W_EN  = back_en;
    assign STATE = state;

    // State register and boot delay counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_BOOT;
            boot_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_BOOT) begin
                boot_cnt <= boot_cnt + 1'b1;
            end
        end
    end

    // Next-state decode; MWAIT release skips the memory-wait rule
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT: begin
                if (boot_cnt == BOOT_LAST) state_nxt = S_RUN;
            end
            S_RUN, S_MWAIT: begin
                if (mem_wait)      state_nxt = S_MWAIT;
                else if (HALT_REQ) state_nxt = S_HALT;
                else               state_nxt = S_RUN;
            end
            default: begin
                if (RESUME && !HALT_REQ) state_nxt = S_RUN;
            end
        endcase
    end

    // Output decode: enables, clears and PC control in priority order
    always_comb begin
        PC_EN    = 1'b0;
        PC_SEL   = 2'b00;
        front_en = 1'b0;
        back_en  = 1'b0;
        D_CLR    = 1'b0;
        E_CLR    = 1'b0;
        redirect = 1'b0;
        case (state)
            S_BOOT: begin
                // flush bubbles through every stage while the PC is held
                front_en = 1'b1;
                back_en  = 1'b1;
                D_CLR    = 1'b1;
                E_CLR    = 1'b1;
            end
            S_RUN, S_MWAIT: begin
                if (mem_wait) begin
                    // freeze everything, no clears
                end else if (HALT_REQ) begin
                    front_en = 1'b1;
                    back_en  = 1'b1;
                    D_CLR    = 1'b1;
                end else if (BR_TAKEN) begin
                    // E redirect squashes D and E, including any load-use or JAL
                    PC_EN    = 1'b1;
                    PC_SEL   = 2'b01;
                    front_en = 1'b1;
                    back_en  = 1'b1;
                    D_CLR    = 1'b1;
                    E_CLR    = 1'b1;
                    redirect = 1'b1;
                end else if (LOAD_USE) begin
                    back_en  = 1'b1;
                    E_CLR    = 1'b1;
                end else if (JAL_D) begin
                    PC_EN    = 1'b1;
                    PC_SEL   = 2'b10;
                    front_en = 1'b1;
                    back_en  = 1'b1;
                    D_CLR    = 1'b1;
                    redirect = 1'b1;
                end else if (!IMEM_RDY) begin
                    front_en = 1'b1;
                    back_en  = 1'b1;
                    D_CLR    = 1'b1;
                end else begin
                    PC_EN    = 1'b1;
                    front_en = 1'b1;
                    back_en  = 1'b1;
                end
            end
            default: begin
                // HALT: hold everything until resumed
            end
        endcase
    end

    // Per-stage valid bits follow their stage register enables
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            STAGE_VALID <= 4'b0000;
        end else begin
            if (D_EN) STAGE_VALID[0] <= d_src && !D_CLR;
            if (E_EN) STAGE_VALID[1] <= STAGE_VALID[0] && !E_CLR;
            if (M_EN) STAGE_VALID[2] <= STAGE_VALID[1];
            if (W_EN) STAGE_VALID[3] <= STAGE_VALID[2];
        end
    end

    // Stall and flush event counters, active only while fetching
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else if (active) begin
            if (!PC_EN)   STALL_CNT <= STALL_CNT + 1'b1;
            if (redirect) FLUSH_CNT <= FLUSH_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed per-cycle vectors for pipe_ctrl. The driver applies
// inputs after each rising edge and queues the hand-computed response for
// that cycle; the monitor pops and compares on every falling edge.
`timescale 1ns/1ps

module tb_pipe_ctrl;

    localparam int CNT_W = 32;
    localparam int EW    = 10 + 2 + 4 + CNT_W + CNT_W;

    // control vector {PC_EN, PC_SEL, F_EN, D_EN, E_EN, M_EN, W_EN, D_CLR, E_CLR}
    localparam logic [9:0] C_BOOT = 10'b0_00_11111_11;
    localparam logic [9:0] C_RUN  = 10'b1_00_11111_00;
    localparam logic [9:0] C_FRZ  = 10'b0_00_00000_00;
    localparam logic [9:0] C_BR   = 10'b1_01_11111_11;
    localparam logic [9:0] C_LU   = 10'b0_00_00111_01;
    localparam logic [9:0] C_JAL  = 10'b1_10_11111_10;
    localparam logic [9:0] C_NOI  = 10'b0_00_11111_10;

    // input vector {LOAD_USE, BR_TAKEN, JAL_D, IMEM_RDY, DMEM_REQ, DMEM_RDY, HALT_REQ, RESUME}
    localparam logic [7:0] I_IDLE  = 8'b0001_0000;
    localparam logic [7:0] I_LU    = 8'b1001_0000;
    localparam logic [7:0] I_BRLU  = 8'b1101_0000;
    localparam logic [7:0] I_JAL   = 8'b0011_0000;
    localparam logic [7:0] I_NOI   = 8'b0000_0000;
    localparam logic [7:0] I_MW    = 8'b0001_1000;
    localparam logic [7:0] I_MREL  = 8'b0001_1100;
    localparam logic [7:0] I_MRBR  = 8'b0101_1100;
    localparam logic [7:0] I_HALTB = 8'b0101_0010;
    localparam logic [7:0] I_HR    = 8'b0001_0011;
    localparam logic [7:0] I_RES   = 8'b0001_0001;

    localparam logic [1:0] S_BOOT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_MWAIT = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    logic             CLK;
    logic             RST_N;
    logic             LOAD_USE, BR_TAKEN, JAL_D, IMEM_RDY;
    logic             DMEM_REQ, DMEM_RDY, HALT_REQ, RESUME;
    logic             PC_EN;
    logic [1:0]       PC_SEL;
    logic             F_EN, D_EN, E_EN, M_EN, W_EN, D_CLR, E_CLR;
    logic [3:0]       STAGE_VALID;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

    logic [EW-1:0] exp_q[$];
    int            checks;
    int            errors;
    int            n_popped;
    logic          drv_done;

    pipe_ctrl #(.BOOT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .LOAD_USE(LOAD_USE), .BR_TAKEN(BR_TAKEN), .JAL_D(JAL_D), .IMEM_RDY(IMEM_RDY),
        .DMEM_REQ(DMEM_REQ), .DMEM_RDY(DMEM_RDY), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
        .PC_EN(PC_EN), .PC_SEL(PC_SEL),
        .F_EN(F_EN), .D_EN(D_EN), .E_EN(E_EN), .M_EN(M_EN), .W_EN(W_EN),
        .D_CLR(D_CLR), .E_CLR(E_CLR),
        .STAGE_VALID(STAGE_VALID), .STATE(STATE),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic drive(input logic [7:0] iv);
        {LOAD_USE, BR_TAKEN, JAL_D, IMEM_RDY, DMEM_REQ, DMEM_RDY, HALT_REQ, RESUME} = iv;
    endtask

    task automatic expect_out(input logic [9:0] ctrl, input logic [1:0] st, input logic [3:0] v,
                              input int stall, input int flush);
        exp_q.push_back({ctrl, st, v, CNT_W'(stall), CNT_W'(flush)});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One cycle: apply inputs, queue the expected response, advance
    task automatic cyc(input logic [7:0] iv, input logic [9:0] ctrl, input logic [1:0] st,
                       input logic [3:0] v, input int stall, input int flush);
        drive(iv);
        expect_out(ctrl, st, v, stall, flush);
        tick();
    endtask

    // Monitor / scoreboard
    initial begin
        logic [EW-1:0]    e;
        logic [9:0]       act_ctrl;
        n_popped = 0;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act_ctrl = {PC_EN, PC_SEL, F_EN, D_EN, E_EN, M_EN, W_EN, D_CLR, E_CLR};
                checks += 5;
                if (act_ctrl !== e[EW-1 -: 10]) begin
                    errors++;
                    $display("FAIL ctrl[%0d]: got %b expected %b", n_popped, act_ctrl, e[EW-1 -: 10]);
                end
                if (STATE !== e[EW-11 -: 2]) begin
                    errors++;
                    $display("FAIL state[%0d]: got %b expected %b", n_popped, STATE, e[EW-11 -: 2]);
                end
                if (STAGE_VALID !== e[EW-13 -: 4]) begin
                    errors++;
                    $display("FAIL stage_valid[%0d]: got %b expected %b", n_popped, STAGE_VALID, e[EW-13 -: 4]);
                end
                if (STALL_CNT !== e[2*CNT_W-1 -: CNT_W]) begin
                    errors++;
                    $display("FAIL stall_cnt[%0d]: got %0d expected %0d", n_popped, STALL_CNT, e[2*CNT_W-1 -: CNT_W]);
                end
                if (FLUSH_CNT !== e[CNT_W-1:0]) begin
                    errors++;
                    $display("FAIL flush_cnt[%0d]: got %0d expected %0d", n_popped, FLUSH_CNT, e[CNT_W-1:0]);
                end
                n_popped++;
            end
        end
    end

    // Driver: directed sequence with hand-computed responses
    initial begin
        checks   = 0;
        errors   = 0;
        drv_done = 1'b0;
        RST_N    = 1'b0;
        drive(I_IDLE);
        repeat (2) @(posedge CLK);
        #1;
        cyc(I_IDLE, C_BOOT, S_BOOT, 4'b0000, 0, 0);   // held in reset

        // boot: four BOOT cycles, then valid bits walk in
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) cyc(I_IDLE, C_BOOT, S_BOOT, 4'b0000, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0000, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0001, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0011, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0111, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b1111, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b1111, 0, 0);

        // load-use bubble into E
        cyc(I_LU,   C_LU,  S_RUN, 4'b1111, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b1101, 1, 0);
        // branch wins over simultaneous load-use
        cyc(I_BRLU, C_BR,  S_RUN, 4'b1011, 1, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0100, 1, 1);
        // JAL redirect from D
        cyc(I_JAL,  C_JAL, S_RUN, 4'b1001, 1, 1);
        // fetch miss: bubble into D
        cyc(I_NOI,  C_NOI, S_RUN, 4'b0010, 1, 2);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0100, 2, 2);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b1001, 2, 2);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0011, 2, 2);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0111, 2, 2);

        // three wait-state cycles, then release
        cyc(I_MW,   C_FRZ, S_RUN,   4'b1111, 2, 2);
        cyc(I_MW,   C_FRZ, S_MWAIT, 4'b1111, 3, 2);
        cyc(I_MW,   C_FRZ, S_MWAIT, 4'b1111, 4, 2);
        cyc(I_MREL, C_RUN, S_MWAIT, 4'b1111, 5, 2);
        cyc(I_IDLE, C_RUN, S_RUN,   4'b1111, 5, 2);
        // release from MWAIT with a branch taken the same cycle
        cyc(I_MW,   C_FRZ, S_RUN,   4'b1111, 5, 2);
        cyc(I_MRBR, C_BR,  S_MWAIT, 4'b1111, 6, 2);
        cyc(I_IDLE, C_RUN, S_RUN,   4'b1100, 6, 3);

        // halt request outranks the branch; five HALT cycles then resume
        cyc(I_HALTB, C_NOI, S_RUN,  4'b1001, 6, 3);
        cyc(I_BRLU,  C_FRZ, S_HALT, 4'b0010, 7, 3);
        cyc(I_IDLE,  C_FRZ, S_HALT, 4'b0010, 7, 3);
        cyc(I_HR,    C_FRZ, S_HALT, 4'b0010, 7, 3);
        cyc(I_IDLE,  C_FRZ, S_HALT, 4'b0010, 7, 3);
        cyc(I_RES,   C_FRZ, S_HALT, 4'b0010, 7, 3);
        cyc(I_IDLE,  C_RUN, S_RUN,  4'b0010, 7, 3);
        cyc(I_IDLE,  C_RUN, S_RUN,  4'b0101, 7, 3);

        // enter MWAIT, then assert reset between rising edges
        cyc(I_MW, C_FRZ, S_RUN,   4'b1011, 7, 3);
        cyc(I_MW, C_FRZ, S_MWAIT, 4'b1011, 8, 3);
        drive(I_MW);
        #1;
        RST_N = 1'b0;
        expect_out(C_BOOT, S_BOOT, 4'b0000, 0, 0);
        tick();
        cyc(I_MW, C_BOOT, S_BOOT, 4'b0000, 0, 0);

        // fresh boot after the mid-stall reset
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) cyc(I_IDLE, C_BOOT, S_BOOT, 4'b0000, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0000, 0, 0);
        cyc(I_IDLE, C_RUN, S_RUN, 4'b0001, 0, 0);
        drv_done = 1'b1;
    end

    // Completion: bounded drain of the expected queue, then report
    initial begin
        int waited;
        waited = 0;
        wait (drv_done);
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
